// File: rtl/hot_tracker_query_ctrl.sv
// Epoch scheduler and drain engine for hot_tracker: issues query pulses, drains the
// top-K stream into a FWFT FIFO (sentinels dropped). Drain stalls while the FIFO is full.
module hot_tracker_query_ctrl #(
  parameter int ADDR_SIZE      = 22,
  parameter int NUM_ENTRY      = 25,
  parameter int K_W            = 5,
  parameter int EPOCH_W        = 32,
  parameter int EPOCH_CNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_enable,
  input  logic [EPOCH_W-1:0]     cfg_epoch_cycles,
  input  logic [K_W-1:0]         cfg_max_k,
  input  logic                   sw_query_req,
  input  logic                   err_clr,
  output logic                   ht_query_en,
  input  logic                   ht_query_ready,
  input  logic                   ht_mig_addr_en,
  input  logic [ADDR_SIZE-1:0]   ht_mig_addr,
  output logic                   ht_mig_addr_ready,
  output logic                   out_valid,
  output logic [ADDR_SIZE-1:0]   out_addr,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done_pulse,
  output logic [EPOCH_CNT_W-1:0] epoch_cnt,
  output logic [K_W-1:0]         last_count,
  output logic                   timeout_err
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RDY, DRAIN, DONE} state_t;

  state_t                 state;
  logic [EPOCH_W-1:0]     timer;
  logic [TO_W-1:0]        to_cnt;
  logic [K_W-1:0]         drain_cnt;
  logic [ADDR_SIZE-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr;
  logic [FIFO_AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;

  logic [K_W-1:0] eff_k;
  logic           timer_on;
  logic           trigger;
  logic           fifo_full;
  logic           accept;
  logic           is_sentinel;
  logic           push;
  logic           pop;
  logic           timeout_hit;

  assign eff_k       = (cfg_max_k == '0) ? K_W'(NUM_ENTRY) : cfg_max_k;
  assign timer_on    = cfg_enable && (cfg_epoch_cycles != '0);
  assign trigger     = sw_query_req || (timer_on && (timer == cfg_epoch_cycles - EPOCH_W'(1)));
  assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign ht_mig_addr_ready = (state == DRAIN) && ht_mig_addr_en && !fifo_full && (drain_cnt < eff_k);
  assign accept      = ht_mig_addr_en && ht_mig_addr_ready;
  assign is_sentinel = &ht_mig_addr;
  assign push        = accept && !is_sentinel;
  assign pop         = out_ready && (fifo_cnt != '0);
  assign timeout_hit = (state == WAIT_RDY) && !ht_query_ready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  assign ht_query_en = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign done_pulse  = (state == DONE);
  assign out_valid   = (fifo_cnt != '0);
  assign out_addr    = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      to_cnt     <= '0;
      drain_cnt  <= '0;
      last_count <= '0;
      epoch_cnt  <= '0;
    end else begin
      timer <= '0;
      case (state)
        IDLE: begin
          if (trigger)         state <= ISSUE;
          else if (timer_on)   timer <= timer + EPOCH_W'(1);
          else if (cfg_enable) timer <= timer;
        end
        ISSUE: begin
          drain_cnt <= '0;
          to_cnt    <= '0;
          state     <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (ht_query_ready)   state  <= DRAIN;
          else if (timeout_hit) state  <= IDLE;
          else                  to_cnt <= to_cnt + TO_W'(1);
        end
        DRAIN: begin
          // A full FIFO with en still high simply holds here; no timeout.
          if (!ht_mig_addr_en) begin
            state <= DONE;
          end else if (accept) begin
            if (is_sentinel) begin
              state <= DONE;
            end else begin
              drain_cnt <= drain_cnt + K_W'(1);
              if (drain_cnt + K_W'(1) == eff_k) state <= DONE;
            end
          end
        end
        DONE: begin
          last_count <= drain_cnt;
          epoch_cnt  <= epoch_cnt + EPOCH_CNT_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timeout_err <= 1'b0;
    else if (err_clr)     timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ht_mig_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
